i2c_reg_sequencer: RTL

//   Transaction-level controller for the byte-level I2C master (I2C_M).

---
 rtl/i2c_reg_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_sequencer.sv
// Sequences one register read/write command into START/addr/reg/data/STOP byte steps for the byte-level I2C master.
// Latency: every step is 1 ISSUE cycle plus a WAIT until completion. A write with a zero-delay engine finishes 10 cycles after accept.
// Backpressure: cmd_ready is high only in IDLE, and each step waits for exactly one completion pulse or for the watchdog.
//
// Ports:
//   clock, reset                    system clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake; cmd_rnw, cmd_dev, cmd_reg, cmd_wdata latched on accept
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion pulse, read data, status (0 ok, 1 nack, 2 timeout, 3 watchdog)
//   busy                            high from accept through the rsp_valid cycle
//   m_go, m_start, m_stop, m_rw,
//   m_data_w                        issue pulse and its qualifiers/byte to the byte engine
//   m_data_r, m_ack, m_nack,
//   m_timeout                       read byte and completion pulses from the byte engine
//
// Optional feature: define I2C_SEQ_RETRY_EN to retry an address NACK (in ADDR_W or RSTART) up to MAX_RETRY times.
// Each retry goes through STOP and then restarts from ADDR_W.

module i2c_reg_sequencer #(
  parameter int WDOG_CYC  = 4000000,
  parameter int WDOG_W    = 22,
  parameter int MAX_RETRY = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  output logic [7:0] m_data_w,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_rw,
  output logic       m_go,
  input  logic [7:0] m_data_r,
  input  logic       m_ack,
  input  logic       m_nack,
  input  logic       m_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_W, S_REG, S_WDATA, S_RSTART, S_RDATA, S_STOP, S_DONE
  } state_t;

  // The watchdog expires on the WDOG_CYC-th consecutive WAIT cycle that has no completion.
  localparam logic [WDOG_W-1:0] WdogLast = WDOG_W'(WDOG_CYC - 1);

  state_t            state_q, state_d;
  logic              wait_q, wait_d;      // 0 = ISSUE cycle of the current step, 1 = WAIT
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rnw_q, rnw_d;
  logic [6:0]        dev_q, dev_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;

`ifdef I2C_SEQ_RETRY_EN
  localparam int RcW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RcW-1:0] RetryMax = RcW'(MAX_RETRY);
  logic [RcW-1:0] retry_q, retry_d;
  logic           rpend_q, rpend_d;       // STOP in progress belongs to a retry, not to the end of the command
`endif

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      wdog_q  <= '0;
      err_q   <= 2'd0;
      rdata_q <= 8'h00;
      rnw_q   <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
`ifdef I2C_SEQ_RETRY_EN
      retry_q <= '0;
      rpend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rnw_q   <= rnw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
`ifdef I2C_SEQ_RETRY_EN
      retry_q <= retry_d;
      rpend_q <= rpend_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rnw_d     = rnw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
`ifdef I2C_SEQ_RETRY_EN
    retry_d   = retry_q;
    rpend_d   = rpend_q;
`endif
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    m_go      = 1'b0;
    m_start   = 1'b0;
    m_stop    = 1'b0;
    m_rw      = 1'b0;
    m_data_w  = 8'h00;

    // Qualifiers depend only on the state and the latched command.
    // They therefore hold stable through both ISSUE and WAIT.
    case (state_q)
      S_ADDR_W: begin m_start = 1'b1; m_data_w = {dev_q, 1'b0}; end
      S_REG:    m_data_w = reg_q;
      S_WDATA:  m_data_w = wdata_q;
      S_RSTART: begin m_start = 1'b1; m_data_w = {dev_q, 1'b1}; end
      S_RDATA:  m_rw = 1'b1;
      S_STOP:   m_stop = 1'b1;
      default:  ;
    endcase

    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rnw_d   = cmd_rnw;
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          wdata_d = cmd_wdata;
          err_d   = 2'd0;
          rdata_d = 8'h00;
          wait_d  = 1'b0;
          state_d = S_ADDR_W;
`ifdef I2C_SEQ_RETRY_EN
          retry_d = '0;
          rpend_d = 1'b0;
`endif
        end
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        if (!wait_q) begin
          m_go   = 1'b1;
          wait_d = 1'b1;
          wdog_d = '0;
        end else if (m_ack) begin
          // A completion pulse takes priority over a watchdog expiry in the same cycle.
          wait_d = 1'b0;
          case (state_q)
            S_ADDR_W: state_d = S_REG;
            S_REG:    state_d = rnw_q ? S_RSTART : S_WDATA;
            S_WDATA:  state_d = S_STOP;
            S_RSTART: state_d = S_RDATA;
            S_RDATA: begin
              rdata_d = m_data_r;
              state_d = S_STOP;
            end
            S_STOP: begin
`ifdef I2C_SEQ_RETRY_EN
              state_d = rpend_q ? S_ADDR_W : S_DONE;
              rpend_d = 1'b0;
`else
              state_d = S_DONE;
`endif
            end
            default:  state_d = S_IDLE;
          endcase
        end else if (m_nack || m_timeout) begin
          wait_d = 1'b0;
          if (state_q == S_STOP) begin
            // A failed STOP keeps any earlier error; otherwise it reports a timeout.
            if (err_q == 2'd0) err_d = 2'd2;
            state_d = S_DONE;
          end else begin
`ifdef I2C_SEQ_RETRY_EN
            if (m_nack && (state_q == S_ADDR_W || state_q == S_RSTART) && (retry_q < RetryMax)) begin
              retry_d = retry_q + 1'b1;
              rpend_d = 1'b1;
            end else begin
              err_d = m_nack ? 2'd1 : 2'd2;
            end
`else
            err_d = m_nack ? 2'd1 : 2'd2;
`endif
            state_d = S_STOP;
          end
        end else if (wdog_q == WdogLast) begin
          // The engine is stuck, so sending a STOP would not help. End the command immediately.
          wait_d  = 1'b0;
          err_d   = 2'd3;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
    endcase
  end

endmodule
